// File: rtl/pipe_regfile_dbg.sv
// Register file with two bypassed combinational read ports, one write port, a start-triggered
// sequential clear (one register per cycle), and a registered debug readout port.
module pipe_regfile_dbg #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_R0  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              startin,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic [ADDR_W-1:0] regNo,
    input  logic              dbg_hold,
    output logic [DATA_W-1:0] val,
    output logic              busy,
    output logic              ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // One extra bit so NUM_REGS == 2**ADDR_W stays representable in the range check.
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NUM_REGS_W;
    endfunction

    function automatic logic is_hardwired_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    // Shared read rule for both read ports and the debug port, including write-first bypass.
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        if (!in_range(a) || is_hardwired_zero(a))
            return '0;
        else if (wr_ok && (waddr == a))
            return wdata;
        else
            return regs[a];
    endfunction

    assign wr_ok = (state == RUN) && we && in_range(waddr) && !is_hardwired_zero(waddr);

    always_comb begin
        rdata1 = lookup(raddr1);
        rdata2 = lookup(raddr2);
    end

    // NOTE: the array is cleared on reset because reset must leave every architectural
    // register at zero; this costs a reset net per flop but no RAM macro is expected here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only, so every flop
            // samples pre-edge values regardless of statement order.
            state   <= IDLE;
            clr_idx <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (startin) begin
                        state   <= CLR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLR: begin
                    regs[clr_idx] <= '0;
                    if (startin) begin
                        clr_idx <= '0;
                    end else if (clr_idx == LAST_IDX) begin
                        state   <= RUN;
                        clr_idx <= '0;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (wr_ok)
                        regs[waddr] <= wdata;
                    if (startin) begin
                        state   <= CLR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Debug readout sees the same post-write view as the read ports, one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            val <= '0;
        else if (!dbg_hold)
            val <= lookup(regNo);
    end

endmodule
